lstm_core_scheduler: RTL and testbench
======================================

// Module: lstm_core_scheduler
// PURPOSE
//  Shares one combinational LSTM cell core (x_t, c_prev, h_prev -> c_new, h_new) between NUM_REQ requesters.
//  Each requester submits a job: up to MAX_STEPS inputs, an initial c0/h0 and a step count.
//  Round-robin arbitration picks a job, runs it one step per clock through the core,
//  then returns final c/h with the job's id on a single valid/ready response channel.
// PARAMETERS
//  WIDTH     18  data width, signed Q6.11 (passed through untouched, no arithmetic here)
//  NUM_REQ   4   number of requesters (>=2)
//  MAX_STEPS 4   max time-steps per job
//  STEP_W    $clog2(MAX_STEPS+1)  width of step-count fields (localparam-style, not overridden)
//  ID_W      $clog2(NUM_REQ)      width of requester id
// PORTS
//  clk        in   1                    clock, all state on rising edge
//  rst_n      in   1                    asynchronous active-low reset
//  req_valid  in   NUM_REQ              per-requester job valid (held until accepted)
//  req_ready  out  NUM_REQ              one-hot accept strobe; at most one bit high
//  req_x      in   NUM_REQ*MAX_STEPS*WIDTH  req r step k at [(r*MAX_STEPS+k)*WIDTH +: WIDTH]
//  req_len    in   NUM_REQ*STEP_W       step count per requester
//  req_c0     in   NUM_REQ*WIDTH        initial cell state
//  req_h0     in   NUM_REQ*WIDTH        initial hidden state
//  core_x     out  WIDTH                x_t to shared core
//  core_c     out  WIDTH                c_prev to shared core
//  core_h     out  WIDTH                h_prev to shared core
//  core_c_new in   WIDTH                core result, valid same cycle
//  core_h_new in   WIDTH                core result, valid same cycle
//  rsp_valid  out  1                    result valid
//  rsp_ready  in   1                    consumer accepts result
//  rsp_id     out  ID_W                 requester index of the result
//  rsp_c      out  WIDTH                final cell state
//  rsp_h      out  WIDTH                final hidden state
//  busy       out  1                    high in RUN or RESP
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, rr_ptr=0, step=0; all outputs 0 incl. req_ready, core_*, rsp_*, busy.
//  Reset mid-job: job is dropped with no response; requester must resubmit.
//  FSM IDLE -> RUN -> RESP -> IDLE.
//  IDLE: if any req_valid, grant g = first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//   req_ready[g]=1 combinationally in that cycle only. On that edge, latch the x vector, c0, h0, id=g
//   and len=min(req_len[g],MAX_STEPS).
//   len==0: go to RESP with rsp_c=c0, rsp_h=h0. Else go to RUN with step=0.
//  RUN: core_x=x_lat[step], core_c=c_reg, core_h=h_reg; each edge c_reg<=core_c_new, h_reg<=core_h_new.
//   step==len-1: rsp_c/rsp_h <= core_c_new/core_h_new, go to RESP. Else step<=step+1.
//  RESP: rsp_valid=1 and rsp_id/c/h held stable until rsp_ready=1.
//   On the accepting edge: rr_ptr <= (id+1) mod NUM_REQ, go to IDLE.
//  core_x/core_c/core_h are 0 outside RUN. No new job is granted while busy.
//  Latency: accept edge, then len RUN cycles; rsp_valid rises the cycle after the last step.
//   Minimum occupancy per job is len+2 cycles when rsp_ready=1.
//  req_valid deasserted before grant: simply not granted (no error). Inputs of non-granted requesters are ignored.
//  Concurrent request in RESP waits; fairness: a continuously-valid requester is granted within NUM_REQ jobs.
// TESTING
//  Bench stub core: c_new=c+x, h_new=h+1 (integers).
//  1 Single job: req0 len=4, x={1,2,3,4}, c0=10, h0=0, rsp_ready=1 -> rsp_c=20, rsp_h=4, rsp_id=0;
//    rsp_valid exactly 5 cycles after the accept edge, 1 cycle wide.
//  2 All 4 valid at once, len=1, x_r=r, rsp_ready=1 -> grant order 0,1,2,3; rsp_c=c0_r+r; one req_ready bit per grant.
//  3 Round-robin: after id=1 completes, req0 and req2 both valid -> req2 granted first, then req0.
//  4 Backpressure: rsp_ready=0 for 6 cycles in RESP -> rsp_* stable, req_ready all 0, busy=1; accepted on the first rsp_ready=1.
//  5 len=0 -> rsp_c=c0, rsp_h=h0 one cycle after accept; len=7 -> clamped to 4 steps.
//  6 rst_n low during RUN step 2 -> all outputs 0 immediately; after release no rsp_valid until a new job completes.

Source files
------------

// File: rtl/lstm_core_scheduler_if.sv
// Requester / shared-core / response bundle for the LSTM core scheduler.
// The scheduler takes the slave side; requesters, core and consumer sit on master.
interface lstm_core_scheduler_if #(
  parameter int WIDTH     = 18,
  parameter int NUM_REQ   = 4,
  parameter int MAX_STEPS = 4
);
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam int ID_W   = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ*MAX_STEPS*WIDTH-1:0] req_x;
  logic [NUM_REQ*STEP_W-1:0]          req_len;
  logic [NUM_REQ*WIDTH-1:0]           req_c0;
  logic [NUM_REQ*WIDTH-1:0]           req_h0;

  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_c;
  logic [WIDTH-1:0] core_h;
  logic [WIDTH-1:0] core_c_new;
  logic [WIDTH-1:0] core_h_new;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [WIDTH-1:0] rsp_c;
  logic [WIDTH-1:0] rsp_h;
  logic             busy;

  modport slave (
    input  req_valid, req_x, req_len, req_c0, req_h0,
    input  core_c_new, core_h_new, rsp_ready,
    output req_ready, core_x, core_c, core_h,
    output rsp_valid, rsp_id, rsp_c, rsp_h, busy
  );

  modport master (
    output req_valid, req_x, req_len, req_c0, req_h0,
    output core_c_new, core_h_new, rsp_ready,
    input  req_ready, core_x, core_c, core_h,
    input  rsp_valid, rsp_id, rsp_c, rsp_h, busy
  );
endinterface

// File: rtl/lstm_core_scheduler.sv
// Round-robin scheduler time-sharing one combinational LSTM cell core between
// NUM_REQ requesters; one step per clock, final c/h returned on a valid/ready channel.
module lstm_core_scheduler #(
  parameter int WIDTH     = 18,
  parameter int NUM_REQ   = 4,
  parameter int MAX_STEPS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lstm_core_scheduler_if.slave   bus
);
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam int ID_W   = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Packed views of the flat request buses; layout matches r*MAX_STEPS+k ordering.
  logic [NUM_REQ-1:0][MAX_STEPS-1:0][WIDTH-1:0] x_in;
  logic [NUM_REQ-1:0][STEP_W-1:0]               len_in;
  logic [NUM_REQ-1:0][WIDTH-1:0]                c0_in;
  logic [NUM_REQ-1:0][WIDTH-1:0]                h0_in;

  assign x_in   = bus.req_x;
  assign len_in = bus.req_len;
  assign c0_in  = bus.req_c0;
  assign h0_in  = bus.req_h0;

  logic [1:0]                    state;
  logic [ID_W-1:0]               rr_ptr;
  logic [ID_W-1:0]               id;
  logic [STEP_W-1:0]             step;
  logic [STEP_W-1:0]             len;
  logic [MAX_STEPS-1:0][WIDTH-1:0] x_lat;
  logic [WIDTH-1:0]              c_reg;
  logic [WIDTH-1:0]              h_reg;
  logic [WIDTH-1:0]              rsp_c_q;
  logic [WIDTH-1:0]              rsp_h_q;

  // Round-robin scan starting at rr_ptr; sum never exceeds 2*NUM_REQ-2.
  logic            gnt_any;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] scan;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    scan    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      scan = sum[ID_W-1:0];
      if (!gnt_any && bus.req_valid[scan]) begin
        gnt_any = 1'b1;
        gnt_id  = scan;
      end
    end
  end

  logic grant;
  assign grant         = rst_n && (state == IDLE) && gnt_any;
  assign bus.req_ready = grant ? (NUM_REQ'(1) << gnt_id) : '0;

  logic [STEP_W-1:0] len_clamp;
  assign len_clamp = (len_in[gnt_id] > STEP_W'(MAX_STEPS)) ? STEP_W'(MAX_STEPS) : len_in[gnt_id];

  logic [WIDTH-1:0] x_cur;
  always_comb begin
    x_cur = '0;
    for (int k = 0; k < MAX_STEPS; k++)
      if (step == STEP_W'(k)) x_cur = x_lat[k];
  end

  logic running;
  assign running    = (state == RUN);
  assign bus.core_x = running ? x_cur : '0;
  assign bus.core_c = running ? c_reg : '0;
  assign bus.core_h = running ? h_reg : '0;

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = id;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_h     = rsp_h_q;
  assign bus.busy      = (state != IDLE);

  logic last_step;
  assign last_step = (step == len - STEP_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      id      <= '0;
      step    <= '0;
      len     <= '0;
      x_lat   <= '0;
      c_reg   <= '0;
      h_reg   <= '0;
      rsp_c_q <= '0;
      rsp_h_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            x_lat <= x_in[gnt_id];
            c_reg <= c0_in[gnt_id];
            h_reg <= h0_in[gnt_id];
            id    <= gnt_id;
            len   <= len_clamp;
            step  <= '0;
            // Zero-length job: the initial state is already the answer.
            if (len_clamp == '0) begin
              rsp_c_q <= c0_in[gnt_id];
              rsp_h_q <= h0_in[gnt_id];
              state   <= RESP;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          c_reg <= bus.core_c_new;
          h_reg <= bus.core_h_new;
          if (last_step) begin
            rsp_c_q <= bus.core_c_new;
            rsp_h_q <= bus.core_h_new;
            state   <= RESP;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rr_ptr <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lstm_core_scheduler.sv
// Bench for lstm_core_scheduler: stub core c+x / h+1, job-level reference model
// checked every cycle, directed scenarios pinned with literals, then random traffic.
module tb_lstm_core_scheduler;
  localparam int W  = 18;
  localparam int N  = 4;
  localparam int MS = 4;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  lstm_core_scheduler_if #(.WIDTH(W), .NUM_REQ(N), .MAX_STEPS(MS)) bus();

  lstm_core_scheduler #(.WIDTH(W), .NUM_REQ(N), .MAX_STEPS(MS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.core_c_new = bus.core_c + bus.core_x;
  assign bus.core_h_new = bus.core_h + W'(1);

  // Job-level reference: prefix sums give every intermediate c and the final result.
  bit           m_job, m_resp;
  int           m_step, m_len, m_id, m_next;
  logic [W-1:0] m_x  [MS];
  logic [W-1:0] m_cp [MS+1];
  logic [W-1:0] m_h0, m_rc, m_rh;
  logic [N-1:0] gnt_mask;
  int           grant_log[$];
  int           rid_log[$];
  logic [W-1:0] rc_log[$];
  logic [W-1:0] rh_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    logic [N-1:0] exp_rdy;
    int g, r, ln;
    exp_rdy = '0;
    g = -1;
    if (!rst_n) begin
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_core_x", 32'(bus.core_x), 0);
      chk("rst_core_c", 32'(bus.core_c), 0);
      chk("rst_core_h", 32'(bus.core_h), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_rsp_c", 32'(bus.rsp_c), 0);
      chk("rst_rsp_h", 32'(bus.rsp_h), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      m_job = 0; m_resp = 0; m_next = 0; m_step = 0;
      gnt_mask = '0;
      return;
    end
    if (!m_job && !m_resp)
      for (int i = 0; i < N; i++) begin
        r = (m_next + i) % N;
        if (g < 0 && bus.req_valid[r]) g = r;
      end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("busy", 32'(bus.busy), 32'(m_job || m_resp));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_resp));
    if (m_job) begin
      chk("core_x", 32'(bus.core_x), 32'(m_x[m_step]));
      chk("core_c", 32'(bus.core_c), 32'(m_cp[m_step]));
      chk("core_h", 32'(bus.core_h), 32'(m_h0 + W'(m_step)));
    end else begin
      chk("core_x_idle", 32'(bus.core_x), 0);
      chk("core_c_idle", 32'(bus.core_c), 0);
      chk("core_h_idle", 32'(bus.core_h), 0);
    end
    if (m_resp) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      chk("rsp_c", 32'(bus.rsp_c), 32'(m_rc));
      chk("rsp_h", 32'(bus.rsp_h), 32'(m_rh));
    end
    gnt_mask = bus.req_ready;
    // Advance the model across the coming clock edge.
    if (m_resp) begin
      if (bus.rsp_ready) begin
        rid_log.push_back(m_id);
        rc_log.push_back(m_rc);
        rh_log.push_back(m_rh);
        m_next = (m_id + 1) % N;
        m_resp = 0;
      end
    end else if (m_job) begin
      m_step++;
      if (m_step == m_len) begin
        m_job = 0;
        m_resp = 1;
      end
    end else if (g >= 0) begin
      ln = int'(bus.req_len[g*SW +: SW]);
      if (ln > MS) ln = MS;
      m_cp[0] = bus.req_c0[g*W +: W];
      for (int k = 0; k < MS; k++) begin
        m_x[k]    = bus.req_x[(g*MS+k)*W +: W];
        m_cp[k+1] = m_cp[k] + m_x[k];
      end
      m_h0   = bus.req_h0[g*W +: W];
      m_rc   = m_cp[ln];
      m_rh   = m_h0 + W'(ln);
      m_id   = g;
      m_len  = ln;
      m_step = 0;
      grant_log.push_back(g);
      if (ln == 0) m_resp = 1;
      else m_job = 1;
    end
  endtask

  // Called at a negedge with inputs for the coming edge already applied; returns at the next negedge.
  task automatic step();
    #1;
    model_cycle();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~gnt_mask;
    @(negedge clk);
  endtask

  task automatic submit(input int r, input int len, input int c0, input int h0,
                        input int x0, input int x1, input int x2, input int x3);
    bus.req_x[(r*MS+0)*W +: W] = W'(x0);
    bus.req_x[(r*MS+1)*W +: W] = W'(x1);
    bus.req_x[(r*MS+2)*W +: W] = W'(x2);
    bus.req_x[(r*MS+3)*W +: W] = W'(x3);
    bus.req_len[r*SW +: SW]    = SW'(len);
    bus.req_c0[r*W +: W]       = W'(c0);
    bus.req_h0[r*W +: W]       = W'(h0);
    bus.req_valid[r]           = 1'b1;
  endtask

  task automatic wait_logs(input string name, input int target);
    int n;
    n = 0;
    while (rid_log.size() < target && n < 200) begin
      step();
      n++;
    end
    chk(name, 32'(rid_log.size() >= target), 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus.busy || bus.req_valid != '0) && n < 200) begin
      step();
      n++;
    end
    chk(name, 32'(bus.busy), 0);
  endtask

  task automatic measure_rsp(output int n);
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int gb, rb, n, cnt;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_len   = '0;
    bus.req_c0    = '0;
    bus.req_h0    = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_busy_lit", 32'(bus.busy), 0);
    rst_n = 1'b1;
    step();

    // All four at once, len 1: grants 0..3 in order, rsp_c = c0 + r.
    gb = grant_log.size(); rb = rid_log.size();
    for (int r = 0; r < N; r++) submit(r, 1, 10*(r+1), 0, r, 0, 0, 0);
    #1;
    chk("t2_first_ready", 32'(bus.req_ready), 1);
    step();
    wait_logs("t2_done", rb + 4);
    for (int i = 0; i < N; i++) begin
      chk("t2_grant", 32'(grant_log[gb+i]), 32'(i));
      chk("t2_rsp_c", 32'(rc_log[rb+i]), 32'(10*(i+1) + i));
      chk("t2_rsp_h", 32'(rh_log[rb+i]), 1);
    end
    wait_idle("t2_idle");

    // Single 4-step job.
    submit(0, 4, 10, 0, 1, 2, 3, 4);
    #1;
    chk("t1_ready", 32'(bus.req_ready), 1);
    step();
    measure_rsp(n);
    chk("t1_latency", 32'(n), 5);
    chk("t1_rsp_c", 32'(bus.rsp_c), 20);
    chk("t1_rsp_h", 32'(bus.rsp_h), 4);
    chk("t1_rsp_id", 32'(bus.rsp_id), 0);
    step();
    chk("t1_pulse", 32'(bus.rsp_valid), 0);
    wait_idle("t1_idle");

    // After id 1 completes, req0 and req2 compete: 2 wins.
    gb = grant_log.size(); rb = rid_log.size();
    submit(1, 1, 0, 0, 7, 0, 0, 0);
    step();
    submit(0, 1, 3, 0, 1, 0, 0, 0);
    submit(2, 1, 4, 0, 2, 0, 0, 0);
    wait_logs("t3_done", rb + 3);
    chk("t3_grant0", 32'(grant_log[gb]), 1);
    chk("t3_grant1", 32'(grant_log[gb+1]), 2);
    chk("t3_grant2", 32'(grant_log[gb+2]), 0);
    wait_idle("t3_idle");

    // Backpressure in RESP for 6 cycles with another request pending.
    bus.rsp_ready = 1'b0;
    submit(3, 2, 100, 7, 5, 6, 0, 0);
    step();
    measure_rsp(n);
    chk("t4_rsp_c", 32'(bus.rsp_c), 111);
    chk("t4_rsp_h", 32'(bus.rsp_h), 9);
    chk("t4_rsp_id", 32'(bus.rsp_id), 3);
    submit(0, 1, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4_hold_valid", 32'(bus.rsp_valid), 1);
      chk("t4_hold_c", 32'(bus.rsp_c), 111);
      chk("t4_hold_ready", 32'(bus.req_ready), 0);
      chk("t4_hold_busy", 32'(bus.busy), 1);
    end
    bus.rsp_ready = 1'b1;
    step();
    chk("t4_accepted", 32'(bus.rsp_valid), 0);
    chk("t4_next_ready", 32'(bus.req_ready), 1);
    wait_idle("t4_idle");

    // len 0 returns initial state next cycle; len 7 clamps to 4 steps.
    submit(2, 0, 55, 66, 9, 9, 9, 9);
    step();
    chk("t5_len0_valid", 32'(bus.rsp_valid), 1);
    chk("t5_len0_c", 32'(bus.rsp_c), 55);
    chk("t5_len0_h", 32'(bus.rsp_h), 66);
    wait_idle("t5a_idle");
    submit(1, 7, 0, 0, 1, 1, 1, 1);
    step();
    measure_rsp(n);
    chk("t5_clamp_latency", 32'(n), 5);
    chk("t5_clamp_c", 32'(bus.rsp_c), 4);
    chk("t5_clamp_h", 32'(bus.rsp_h), 4);
    wait_idle("t5b_idle");

    // Reset during RUN step 2 drops the job.
    submit(0, 4, 0, 0, 1, 2, 3, 4);
    step();
    step();
    step();
    chk("t6_pre_core_x", 32'(bus.core_x), 3);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_core_x", 32'(bus.core_x), 0);
    chk("t6_core_c", 32'(bus.core_c), 0);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("t6_req_ready", 32'(bus.req_ready), 0);
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.rsp_valid) cnt++;
    end
    chk("t6_no_rsp", 32'(cnt), 0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < N; r++)
        if (!bus.req_valid[r] && $urandom_range(0, 99) < 25)
          submit(r, int'($urandom_range(0, 7)), int'($urandom), int'($urandom),
                 int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      bus.rsp_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    bus.rsp_ready = 1'b1;
    wait_idle("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
